// File: rtl/mem_sweep_pkg.sv
// Shared types and helpers for the BRAM sweep controller: FSM states, mode
// encodings and the seeded fill/check pattern.
package mem_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    CHECK = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sweep_state_e;

  localparam logic MODE_CHECK = 1'b0;
  localparam logic MODE_FILL  = 1'b1;

  // Expected word at an address: low wid bits of the address XOR the seed.
  function automatic logic [31:0] pattern(input logic [31:0] addr,
                                          input logic [31:0] seed,
                                          input int unsigned wid);
    logic [31:0] mask;
    mask = (wid >= 32) ? 32'hFFFF_FFFF : ((32'd1 << wid) - 32'd1);
    return (addr ^ seed) & mask;
  endfunction

endpackage

// File: rtl/sweep_addr_gen.sv
// Sweep address sequencing: first, next and last address, stepping over the
// reserved park location.
module sweep_addr_gen #(
  parameter int unsigned DEPTH_MEM = 8192,
  parameter int unsigned PARK_ADDR = DEPTH_MEM - 1
) (
  input  logic [31:0] addr_i,
  output logic [31:0] first_o,
  output logic [31:0] next_o,
  output logic        last_o
);

  localparam logic [31:0] PARK  = 32'(PARK_ADDR);
  localparam logic [31:0] FIRST = (PARK_ADDR == 0) ? 32'd1 : 32'd0;
  localparam logic [31:0] LAST  = (PARK_ADDR == DEPTH_MEM - 1) ? 32'(DEPTH_MEM - 2)
                                                               : 32'(DEPTH_MEM - 1);

  always_comb begin
    first_o = FIRST;
    last_o  = (addr_i == LAST);
    next_o  = (addr_i + 32'd1 == PARK) ? addr_i + 32'd2 : addr_i + 32'd1;
  end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Fills a BRAM with a seeded pattern or reads it back, counting mismatches and
// summing the words read. Writes are parked on a sacrificial word unless filling.
module mem_sweep_ctrl
  import mem_sweep_pkg::*;
#(
  parameter int unsigned WID_MEM   = 9,
  parameter int unsigned DEPTH_MEM = 8192,
  parameter int unsigned PARK_ADDR = DEPTH_MEM - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WID_MEM-1:0] seed,
  output logic               busy,
  output logic               done,
  output logic [31:0]        raddr,
  output logic [31:0]        waddr,
  output logic [WID_MEM-1:0] din,
  input  logic [WID_MEM-1:0] dout,
  output logic [31:0]        mismatch_cnt,
  output logic [31:0]        first_err_addr,
  output logic               err_seen,
  output logic [31:0]        checksum,
  output sweep_state_e       dbg_state
);

  localparam logic [31:0] PARK = 32'(PARK_ADDR);

  sweep_state_e       state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [WID_MEM-1:0] seed_q, seed_d;
  logic [31:0]        raddr_q, raddr_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [WID_MEM-1:0] din_q, din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               drain_q, drain_d;
  logic               tag1_v_q, tag1_v_d, tag2_v_q, tag2_v_d;
  logic [31:0]        tag1_a_q, tag1_a_d, tag2_a_q, tag2_a_d;
  logic [31:0]        mism_q, mism_d;
  logic [31:0]        ferr_q, ferr_d;
  logic               err_q, err_d;
  logic [31:0]        csum_q, csum_d;

  logic [31:0]        first_addr, next_addr;
  logic               last_addr;

  sweep_addr_gen #(
    .DEPTH_MEM (DEPTH_MEM),
    .PARK_ADDR (PARK_ADDR)
  ) u_addr_gen (
    .addr_i  (addr_q),
    .first_o (first_addr),
    .next_o  (next_addr),
    .last_o  (last_addr)
  );

  function automatic logic [WID_MEM-1:0] pat(input logic [31:0] a,
                                             input logic [WID_MEM-1:0] s);
    return WID_MEM'(pattern(a, 32'(s), WID_MEM));
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    seed_d   = seed_q;
    raddr_d  = PARK;
    waddr_d  = PARK;
    din_d    = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    drain_d  = drain_q;
    tag1_v_d = 1'b0;
    tag1_a_d = tag1_a_q;
    tag2_v_d = tag1_v_q;
    tag2_a_d = tag1_a_q;
    mism_d   = mism_q;
    ferr_d   = ferr_q;
    err_d    = err_q;
    csum_d   = csum_q;

    // dout belongs to the address tagged two edges ago
    if (tag2_v_q) begin
      csum_d = csum_q + 32'(dout);
      if (dout != pat(tag2_a_q, seed_q)) begin
        mism_d = (mism_q == 32'hFFFF_FFFF) ? mism_q : mism_q + 32'd1;
        err_d  = 1'b1;
        if (!err_q) ferr_d = tag2_a_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          seed_d = seed;
          mism_d = '0;
          ferr_d = '0;
          err_d  = 1'b0;
          csum_d = '0;
          addr_d = first_addr;
          busy_d = 1'b1;
          if (mode == MODE_FILL) begin
            state_d = FILL;
            waddr_d = first_addr;
            din_d   = pat(first_addr, seed);
          end else begin
            state_d  = CHECK;
            raddr_d  = first_addr;
            tag1_v_d = 1'b1;
            tag1_a_d = first_addr;
          end
        end
      end
      FILL: begin
        if (last_addr) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          addr_d  = next_addr;
          waddr_d = next_addr;
          din_d   = pat(next_addr, seed_q);
        end
      end
      CHECK: begin
        if (last_addr) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          addr_d   = next_addr;
          raddr_d  = next_addr;
          tag1_v_d = 1'b1;
          tag1_a_d = next_addr;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      seed_q   <= '0;
      raddr_q  <= PARK;
      waddr_q  <= PARK;
      din_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drain_q  <= 1'b0;
      tag1_v_q <= 1'b0;
      tag1_a_q <= '0;
      tag2_v_q <= 1'b0;
      tag2_a_q <= '0;
      mism_q   <= '0;
      ferr_q   <= '0;
      err_q    <= 1'b0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      seed_q   <= seed_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drain_q  <= drain_d;
      tag1_v_q <= tag1_v_d;
      tag1_a_q <= tag1_a_d;
      tag2_v_q <= tag2_v_d;
      tag2_a_q <= tag2_a_d;
      mism_q   <= mism_d;
      ferr_q   <= ferr_d;
      err_q    <= err_d;
      csum_q   <= csum_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign raddr          = raddr_q;
  assign waddr          = waddr_q;
  assign din            = din_q;
  assign mismatch_cnt   = mism_q;
  assign first_err_addr = ferr_q;
  assign err_seen       = err_q;
  assign checksum       = csum_q;
  assign dbg_state      = state_q;

endmodule
